// File: rtl/spi_pkg.sv
// spi_pkg: shared types and mode encodings for the system-clocked SPI slave.
// Mode number is {cpol, cpha}, matching the usual SPI mode 0..3 numbering.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    localparam mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous pin plus rise/fall pulses.
// Reset value is RESET_VAL xor i_rstInvert so the sclk copy can reset to the live cpol.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rstInvert,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_stages;
    logic                   r_prev;
    logic                   w_rstVal;

    assign w_rstVal = RESET_VAL ^ i_rstInvert;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stages <= {SYNC_STAGES{w_rstVal}};
            r_prev   <= w_rstVal;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
            r_prev   <= r_stages[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];
    assign o_rise = r_stages[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_stages[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: oversampled SPI slave, all CPOL/CPHA modes, burst words, rx/tx handshakes.
// Define SPI_SLAVE_LSB_FIRST_EN to shift words LSB first (default is MSB first).
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_sclk,
    input  logic              i_ss,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_busy,
    output logic              o_underrun,
    output logic              o_overrun,
    input  logic              i_flag_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic w_sclkSync, w_sclkRise, w_sclkFall;
    logic w_ssSync, w_ssRise, w_ssFall;
    logic w_mosiSync, w_mosiRise, w_mosiFall;
    logic w_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclkSync (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rstInvert(i_cpol), .i_async(i_sclk),
        .o_sync(w_sclkSync), .o_rise(w_sclkRise), .o_fall(w_sclkFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssSync (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rstInvert(1'b0), .i_async(i_ss),
        .o_sync(w_ssSync), .o_rise(w_ssRise), .o_fall(w_ssFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosiSync (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rstInvert(1'b0), .i_async(i_mosi),
        .o_sync(w_mosiSync), .o_rise(w_mosiRise), .o_fall(w_mosiFall)
    );

    assign w_unused = &{1'b0, w_sclkSync, w_ssSync, w_mosiRise, w_mosiFall};

    state_t            r_state;
    mode_t             r_mode;
    logic [DATA_W-1:0] r_txShift, r_rxShift, r_rxData;
    logic [CNT_W-1:0]  r_bitCnt;
    logic              r_miso, r_misoOe, r_txReady, r_rxValid, r_busy, r_underrun, r_overrun;

    logic              w_sampleEdge, w_shiftEdge;
    logic [DATA_W-1:0] w_loadWord, w_txShifted, w_rxShifted;
    logic              w_loadFirst, w_txCurBit, w_txNextBit;

    always_comb begin
        w_sampleEdge = 1'b0;
        w_shiftEdge  = 1'b0;
        case (r_mode)
            MODE0, MODE3: begin
                w_sampleEdge = w_sclkRise;
                w_shiftEdge  = w_sclkFall;
            end
            MODE1, MODE2: begin
                w_sampleEdge = w_sclkFall;
                w_shiftEdge  = w_sclkRise;
            end
            default: ;
        endcase
    end

    assign w_loadWord = i_tx_valid ? i_tx_data : '0;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign w_loadFirst = w_loadWord[0];
    assign w_txCurBit  = r_txShift[0];
    assign w_txNextBit = r_txShift[1];
    assign w_txShifted = {1'b0, r_txShift[DATA_W-1:1]};
    assign w_rxShifted = {w_mosiSync, r_rxShift[DATA_W-1:1]};
`else
    assign w_loadFirst = w_loadWord[DATA_W-1];
    assign w_txCurBit  = r_txShift[DATA_W-1];
    assign w_txNextBit = r_txShift[DATA_W-2];
    assign w_txShifted = {r_txShift[DATA_W-2:0], 1'b0};
    assign w_rxShifted = {r_rxShift[DATA_W-2:0], w_mosiSync};
`endif

    // A shift edge with bit_cnt==0 is either the first cpha=1 leading edge (present bit 0)
    // or the trailing edge right after a cpha=0 word reload, which must not disturb bit 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_mode     <= MODE0;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_rxData   <= '0;
            r_bitCnt   <= '0;
            r_miso     <= 1'b0;
            r_misoOe   <= 1'b0;
            r_txReady  <= 1'b0;
            r_rxValid  <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_txReady <= 1'b0;
            if (r_rxValid && i_rx_ready) r_rxValid <= 1'b0;
            if (i_flag_clr) begin
                r_underrun <= 1'b0;
                r_overrun  <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_miso   <= 1'b0;
                    r_misoOe <= 1'b0;
                    r_busy   <= 1'b0;
                    if (w_ssFall) r_state <= LOAD;
                end
                LOAD: begin
                    r_mode    <= '{cpol: i_cpol, cpha: i_cpha};
                    r_txShift <= w_loadWord;
                    r_txReady <= i_tx_valid;
                    if (!i_tx_valid) r_underrun <= 1'b1;
                    r_miso    <= i_cpha ? 1'b0 : w_loadFirst;
                    r_bitCnt  <= '0;
                    r_misoOe  <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    if (r_bitCnt == CNT_W'(DATA_W)) begin
                        if (!r_rxValid || i_rx_ready) begin
                            r_rxData  <= r_rxShift;
                            r_rxValid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        r_txShift <= w_loadWord;
                        r_txReady <= i_tx_valid;
                        if (!i_tx_valid) r_underrun <= 1'b1;
                        r_miso    <= r_mode.cpha ? r_miso : w_loadFirst;
                        r_bitCnt  <= '0;
                    end else if (w_sampleEdge) begin
                        r_rxShift <= w_rxShifted;
                        r_bitCnt  <= r_bitCnt + CNT_W'(1);
                    end else if (w_shiftEdge) begin
                        if (r_bitCnt != '0) begin
                            r_txShift <= w_txShifted;
                            r_miso    <= w_txNextBit;
                        end else if (r_mode.cpha) begin
                            r_miso <= w_txCurBit;
                        end
                    end
                    if (w_ssRise) begin
                        r_state  <= IDLE;
                        r_bitCnt <= '0;
                        r_miso   <= 1'b0;
                        r_misoOe <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_miso     = r_miso;
    assign o_miso_oe  = r_misoOe;
    assign o_tx_ready = r_txReady;
    assign o_rx_data  = r_rxData;
    assign o_rx_valid = r_rxValid;
    assign o_busy     = r_busy;
    assign o_underrun = r_underrun;
    assign o_overrun  = r_overrun;

endmodule
